// File: rtl/reg_bus_uart_bridge_if.sv
// Peripheral register bus as driven by the UART debug bridge.
// The bridge is the master; the peripheral decoder (via the top-level mux) is the slave.
`timescale 1ns/1ps
interface reg_bus_uart_bridge_if;
    logic [6:0]  register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic        bridge_active;

    modport master (
        output register_index,
        output register_read,
        output register_write,
        output register_write_value,
        output bridge_active,
        input  register_read_value
    );

    modport slave (
        input  register_index,
        input  register_read,
        input  register_write,
        input  register_write_value,
        input  bridge_active,
        output register_read_value
    );
endinterface

// File: rtl/reg_bus_uart_bridge.sv
// UART (8N1) debug initiator for the peripheral register bus: 'W' idx hi lo writes and
// answers 'K'; 'R' idx reads and answers hi, lo; anything malformed answers '?'.
`timescale 1ns/1ps
module reg_bus_uart_bridge #(
    parameter int CLKS_PER_BIT = 217,
    parameter int TIMEOUT_CLKS = 2500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    output logic                  uart_tx,
    reg_bus_uart_bridge_if.master bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 2;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TMO_ZERO  = TW'(0);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [3:0] {
        P_IDLE      = 4'd0,
        P_GET_INDEX = 4'd1,
        P_GET_HI    = 4'd2,
        P_GET_LO    = 4'd3,
        P_BUS_WRITE = 4'd4,
        P_SEND_ACK  = 4'd5,
        P_BUS_READ  = 4'd6,
        P_CAPTURE   = 4'd7,
        P_SEND_HI   = 4'd8,
        P_SEND_LO   = 4'd9,
        P_SEND_ERR  = 4'd10
    } p_state_t;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_q, rx_valid_d;

    logic            tx_busy_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [3:0]      tx_bit_q;
    logic [8:0]      tx_frame_q;
    logic            uart_tx_q;
    logic            tx_start_s;
    logic [7:0]      tx_byte_s;
    logic            tx_done_s;

    p_state_t        state_q, state_d;
    logic            is_read_q, is_read_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      lo_q, lo_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [6:0]      index_q, index_d;
    logic [15:0]     wvalue_q, wvalue_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            active_q, active_d;
    logic            tmo_expired_s;

    assign uart_tx                  = uart_tx_q;
    assign bus.register_index       = index_q;
    assign bus.register_read        = rd_q;
    assign bus.register_write       = wr_q;
    assign bus.register_write_value = wvalue_q;
    assign bus.bridge_active        = active_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= CNT_ZERO;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // RX next state: half-bit start check, then mid-bit sampling of data and stop.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_ONE;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = CNT_ZERO;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_STOP;
                end
            end
            default: begin
                rx_cnt_d   = CNT_ZERO;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX output: a byte is delivered only when its stop bit reads high.
    always_comb begin
        rx_valid_d = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_sync_q;
    end

    assign tx_done_s = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);

    // TX shifter; a start request wins over the finishing stop bit so responses chain back to back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= 4'd0;
            tx_frame_q <= 9'h1FF;
            uart_tx_q  <= 1'b1;
        end else if (tx_start_s) begin
            tx_busy_q  <= 1'b1;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= 4'd0;
            tx_frame_q <= {1'b1, tx_byte_s};
            uart_tx_q  <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q <= CNT_ZERO;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                end else begin
                    uart_tx_q  <= tx_frame_q[0];
                    tx_frame_q <= {1'b1, tx_frame_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CNT_ONE;
            end
        end
    end

    assign tmo_expired_s = (tmo_q == TMO_LAST);

    // Parser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= P_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Parser next state; bytes arriving outside the GET states are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            P_IDLE: begin
                if (rx_valid_q) begin
                    if ((rx_shift_q == 8'h57) || (rx_shift_q == 8'h52)) begin
                        state_d = P_GET_INDEX;
                    end else begin
                        state_d = P_SEND_ERR;
                    end
                end else begin
                    state_d = P_IDLE;
                end
            end
            P_GET_INDEX: begin
                if (rx_valid_q) begin
                    if (rx_shift_q[7]) begin
                        state_d = P_SEND_ERR;
                    end else begin
                        state_d = is_read_q ? P_BUS_READ : P_GET_HI;
                    end
                end else begin
                    state_d = tmo_expired_s ? P_IDLE : P_GET_INDEX;
                end
            end
            P_GET_HI: begin
                if (rx_valid_q) begin
                    state_d = P_GET_LO;
                end else begin
                    state_d = tmo_expired_s ? P_IDLE : P_GET_HI;
                end
            end
            P_GET_LO: begin
                if (rx_valid_q) begin
                    state_d = P_BUS_WRITE;
                end else begin
                    state_d = tmo_expired_s ? P_IDLE : P_GET_LO;
                end
            end
            P_BUS_WRITE: state_d = P_SEND_ACK;
            P_SEND_ACK:  state_d = tx_done_s ? P_IDLE : P_SEND_ACK;
            P_BUS_READ:  state_d = P_CAPTURE;
            P_CAPTURE:   state_d = P_SEND_HI;
            P_SEND_HI:   state_d = tx_done_s ? P_SEND_LO : P_SEND_HI;
            P_SEND_LO:   state_d = tx_done_s ? P_IDLE : P_SEND_LO;
            P_SEND_ERR:  state_d = tx_done_s ? P_IDLE : P_SEND_ERR;
            default:     state_d = P_IDLE;
        endcase
    end

    // Parser outputs: bus strobes/data next values, TX requests and the inter-byte timer.
    always_comb begin
        is_read_d  = is_read_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        tmo_d      = TMO_ZERO;
        index_d    = index_q;
        wvalue_d   = wvalue_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        tx_start_s = 1'b0;
        tx_byte_s  = 8'h00;
        active_d   = (state_d != P_IDLE);
        case (state_q)
            P_IDLE: begin
                if (rx_valid_q) begin
                    is_read_d  = (rx_shift_q == 8'h52);
                    tx_start_s = (state_d == P_SEND_ERR);
                    tx_byte_s  = 8'h3F;
                end else begin
                    is_read_d = is_read_q;
                end
            end
            P_GET_INDEX: begin
                if (rx_valid_q) begin
                    if (rx_shift_q[7]) begin
                        tx_start_s = 1'b1;
                        tx_byte_s  = 8'h3F;
                    end else begin
                        index_d = rx_shift_q[6:0];
                        rd_d    = is_read_q;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            P_GET_HI: begin
                if (rx_valid_q) begin
                    hi_d = rx_shift_q;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            P_GET_LO: begin
                if (rx_valid_q) begin
                    wvalue_d = {hi_q, rx_shift_q};
                    wr_d     = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            P_BUS_WRITE: begin
                tx_start_s = 1'b1;
                tx_byte_s  = 8'h4B;
            end
            P_CAPTURE: begin
                lo_d       = bus.register_read_value[7:0];
                tx_start_s = 1'b1;
                tx_byte_s  = bus.register_read_value[15:8];
            end
            P_SEND_HI: begin
                tx_start_s = tx_done_s;
                tx_byte_s  = lo_q;
            end
            default: begin
                tx_start_s = 1'b0;
            end
        endcase
    end

    // Parser registers, including the registered bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_read_q <= 1'b0;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            tmo_q     <= TMO_ZERO;
            index_q   <= 7'd0;
            wvalue_q  <= 16'h0000;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            is_read_q <= is_read_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            tmo_q     <= tmo_d;
            index_q   <= index_d;
            wvalue_q  <= wvalue_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_uart_bridge.sv
// Directed scoreboard bench for reg_bus_uart_bridge: commands go in serially, expected bus
// cycles and response bytes are queued beforehand and checked as monitors observe them.
`timescale 1ns/1ps
module tb_reg_bus_uart_bridge;
    localparam int CPB = 8;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;

    reg_bus_uart_bridge_if bus_if ();

    reg_bus_uart_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [6:0]  idx;
        logic [15:0] val;
    } bus_ev_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         wr_cyc = 0;
    int         rd_cyc = 0;
    bit         tx_abort = 1'b0;
    bus_ev_t    exp_bus[$];
    logic [7:0] exp_tx[$];
    int         tx_starts[$];
    logic [15:0] mem [0:127];
    logic [15:0] rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Peripheral model: read data registered on the edge that samples the strobe.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) begin
                mem[i] <= (i == 6) ? 16'h000A : (16'hA500 | 16'(i));
            end
            rdata <= 16'h0000;
        end else begin
            if (bus_if.register_write) mem[bus_if.register_index] <= bus_if.register_write_value;
            if (bus_if.register_read) rdata <= mem[bus_if.register_index];
        end
    end
    assign bus_if.register_read_value = rdata;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor: every strobe must match the next queued bus cycle.
    initial begin : bus_mon
        logic    prev_strobe;
        bus_ev_t ev;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.register_write || bus_if.register_read) begin
                chk("strobe_excl", {31'd0, bus_if.register_write & bus_if.register_read}, 32'd0);
                chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
                if (bus_if.register_write) wr_cyc = cyc;
                else rd_cyc = cyc;
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", {8'd0, bus_if.register_write, bus_if.register_index,
                        bus_if.register_write_value}, 32'hFFFF_FFFF);
                end else begin
                    ev = exp_bus.pop_front();
                    chk("bus_cycle", {8'd0, bus_if.register_write, bus_if.register_index,
                        bus_if.register_write ? bus_if.register_write_value : 16'h0000}, {8'd0, ev});
                end
            end
            prev_strobe = bus_if.register_write | bus_if.register_read;
        end
    end

    // TX monitor: decodes 8N1 frames and compares against queued response bytes.
    initial begin : tx_mon
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                tx_starts.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = uart_tx;
                if (tx_abort) begin
                    tx_abort = 1'b0;
                end else begin
                    chk("tx_stop", {31'd0, stop_bit}, 32'd1);
                    if (exp_tx.size() == 0) chk("tx_unexpected", {24'd0, b}, 32'h100);
                    else chk("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_rsp(input string tag);
        int k = 0;
        while ((exp_tx.size() != 0 || exp_bus.size() != 0) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_pending"}, exp_tx.size() + exp_bus.size(), 0);
        repeat (CPB) @(negedge clk);
        chk({tag, "_active"}, {31'd0, bus_if.bridge_active}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_read", {31'd0, bus_if.register_read}, 32'd0);
        chk("rst_write", {31'd0, bus_if.register_write}, 32'd0);
        chk("rst_index", {25'd0, bus_if.register_index}, 32'd0);
        chk("rst_wvalue", {16'd0, bus_if.register_write_value}, 32'd0);
        chk("rst_active", {31'd0, bus_if.bridge_active}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // write 57 02 00 3F
        tx_starts.delete();
        exp_bus.push_back({1'b1, 7'd2, 16'h003F});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h02); send_byte(8'h00);
        chk("wr_active_mid", {31'd0, bus_if.bridge_active}, 32'd1);
        send_byte(8'h3F);
        wait_rsp("wr");
        chk("wr_tx_count", tx_starts.size(), 1);
        if (tx_starts.size() > 0) chk("wr_ack_latency", tx_starts[0] - wr_cyc, 1);

        // read 52 06 -> 00 0A back to back
        tx_starts.delete();
        exp_bus.push_back({1'b0, 7'd6, 16'h0000});
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h0A);
        send_byte(8'h52); send_byte(8'h06);
        wait_rsp("rd");
        chk("rd_tx_count", tx_starts.size(), 2);
        if (tx_starts.size() > 1) begin
            chk("rd_rsp_latency", tx_starts[0] - rd_cyc, 2);
            chk("rd_back_to_back", tx_starts[1] - tx_starts[0], 10 * CPB);
        end

        // bad command byte, then bad index byte
        exp_tx.push_back(8'h3F);
        send_byte(8'h41);
        wait_rsp("err_cmd");
        exp_tx.push_back(8'h3F);
        send_byte(8'h52); send_byte(8'h85);
        wait_rsp("err_idx");

        // glitch shorter than half a bit, then a framing-errored byte
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        chk("glitch_active", {31'd0, bus_if.bridge_active}, 32'd0);
        send_byte(8'h41, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        chk("frame_active", {31'd0, bus_if.bridge_active}, 32'd0);
        exp_bus.push_back({1'b1, 7'h10, 16'h1234});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34);
        wait_rsp("post_frame");

        // inter-byte timeout abandons the write; next read sees the untouched register
        send_byte(8'h57); send_byte(8'h01); send_byte(8'h00);
        repeat (TMO + 2) @(negedge clk);
        chk("tmo_active", {31'd0, bus_if.bridge_active}, 32'd0);
        exp_bus.push_back({1'b0, 7'd1, 16'h0000});
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h01);
        send_byte(8'h52); send_byte(8'h01);
        wait_rsp("post_tmo");

        // reset in the middle of the value_hi response
        exp_bus.push_back({1'b0, 7'd6, 16'h0000});
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h0A);
        send_byte(8'h52); send_byte(8'h06);
        repeat (4 * CPB) @(negedge clk);
        tx_abort = 1'b1;
        exp_tx.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_mid_active", {31'd0, bus_if.bridge_active}, 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_mid_strobes", {30'd0, bus_if.register_read, bus_if.register_write}, 32'd0);
        rst_n = 1'b1;
        repeat (15 * CPB) @(negedge clk);
        chk("rst_after_tx", {31'd0, uart_tx}, 32'd1);
        exp_bus.push_back({1'b1, 7'h22, 16'hBEEF});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h22); send_byte(8'hBE); send_byte(8'hEF);
        wait_rsp("post_rst");

        chk("final_queues", exp_bus.size() + exp_tx.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_bus_uart_bridge.md
# reg_bus_uart_bridge

Debug initiator for the ulisp peripheral register bus: it receives 8N1 serial commands from a host and drives register reads and writes exactly as the core does, returning results over serial. It sits in the FPGA top beside the ulisp core. The top level muxes the bridge's bus outputs onto the peripheral decoder whenever `bridge_active` is high, so LEDs, 7-segment digits and buttons can be poked without firmware.

## Interface
- `CLKS_PER_BIT`, default 217, clk cycles per UART bit (25 MHz / 115200); minimum 4.
- `TIMEOUT_CLKS`, default 2500000, idle clk cycles allowed between bytes of one command before it is abandoned.
- `clk`  in  1  system clock. All logic is in this single clock domain.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `uart_rx`  in  1  serial in, idle high, asynchronous to `clk`.
- `uart_tx`  out  1  serial out, idle high.
- `register_index`  out  7  register address.
- `register_read`  out  1  one-cycle read strobe.
- `register_write`  out  1  one-cycle write strobe.
- `register_write_value`  out  16  write data.
- `register_read_value`  in  16  read data, registered by the peripheral on the edge that samples `register_read`.
- `bridge_active`  out  1  high from acceptance of a command byte until its response stop bit ends.

## Operation
- RX path:
  - `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter. The line is resampled at half a bit; if it is high, the start is false and RX returns to idle.
  - 8 data bits are sampled LSB first at mid-bit, then the stop bit. A stop bit of 0 is a framing error: the byte is dropped and nothing else happens.
- TX path: 8N1, LSB first, one start bit, one stop bit, each bit `CLKS_PER_BIT` cycles.
- Command protocol:
  - Write: 0x57, index, value_hi, value_lo. The bridge writes the register, then sends 0x4B.
  - Read: 0x52, index. The bridge reads the register, then sends value_hi followed by value_lo.
- Error cases:
  - Any other first byte: send 0x3F, return to IDLE.
  - Index byte with bit 7 set: send 0x3F, abort the command.
- Parser states and transitions:
  - IDLE -> GET_INDEX on 0x57 or 0x52.
  - GET_INDEX -> GET_HI (write) or BUS_READ (read).
  - GET_HI -> GET_LO -> BUS_WRITE.
  - BUS_WRITE -> SEND_ACK -> IDLE.
  - BUS_READ -> CAPTURE -> SEND_HI -> SEND_LO -> IDLE.
  - SEND_ERR -> IDLE.
- Inter-byte timeout: in GET_INDEX, GET_HI or GET_LO, `TIMEOUT_CLKS` cycles without a new byte returns the parser to IDLE silently, with no bus cycle.
- Bytes that complete while any SEND state is active are discarded. The host must wait for each response before sending the next command.
- Framing-errored bytes do not restart the timeout.

## Timing
- Reset values:
  - `uart_tx`=1.
  - `register_read`=0, `register_write`=0.
  - `register_index`=0, `register_write_value`=0.
  - `bridge_active`=0.
  - Parser in IDLE, RX and TX idle.
- Reset asserted mid-command or mid-transmission aborts it immediately. `uart_tx` returns high asynchronously, and no strobe may fire afterwards.
- RX byte valid 1 cycle after the stop-bit mid-sample. The parser consumes it on the same cycle.
- Write path:
  - `register_write` is high for exactly 1 cycle, starting the cycle after value_lo is consumed.
  - `register_index` and `register_write_value` are valid in that cycle.
- Read path:
  - `register_read` is high for exactly 1 cycle, starting the cycle after index is consumed.
  - `register_read_value` is captured on the next cycle (CAPTURE state), 1 cycle after the strobe.
- `register_index` and `register_write_value` hold their last values until the next command loads them.
- Read and write strobes are never high together.
- The TX start bit begins the cycle after BUS_WRITE or CAPTURE.
- Two-byte responses go back to back: the hi stop bit is followed immediately by the lo start bit.
- `bridge_active` rises the cycle after the command byte is consumed. It falls the cycle after the final stop bit, or the cycle after the timeout fires.

## Test plan
- Write: with `CLKS_PER_BIT`=8, send 57 02 00 3F. Required: `register_write` is a single-cycle pulse with index=2 and value=0x003F, then `uart_tx` sends 0x4B.
- Read: send 52 06 with the model returning 0x000A, registered on the strobe. Required: `register_read` is a one-cycle pulse with index=6, then TX sends 00 then 0A back to back.
- Errors: send 0x41. Required: TX sends 0x3F and no strobe fires. Then send 52 85. Required: TX sends 0x3F, no strobe fires, parser is back in IDLE.
- Line faults: a glitch low shorter than half a bit produces no byte. A byte with stop bit 0 is dropped, and the next valid command still works.
- Timeout: send 57 01 00 then go idle for `TIMEOUT_CLKS`+1 cycles. Required: no strobe, `bridge_active` falls. A following 52 01 completes normally.
- Reset: assert `reset` low during the TX of value_hi. Required: `uart_tx`=1 at once, all strobes stay 0, and after release a full write transaction succeeds.
